// File: rtl/rf_access_ctrl.sv
// rf_access_ctrl: sequences register-file read/write cycles for operand fetch and write-back (option: RF_ZERO_GUARD_EN hard-wires r0 to zero)
module rf_access_ctrl #(
  parameter int DATA_INDEX_LIMIT = 31,
  parameter int REG_ADDR_INDEX_LIMIT = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            RD_REQ,
  input  logic [REG_ADDR_INDEX_LIMIT:0]   RS_ADDR,
  input  logic [REG_ADDR_INDEX_LIMIT:0]   RT_ADDR,
  output logic                            RD_ACK,
  output logic [DATA_INDEX_LIMIT:0]       OP1,
  output logic [DATA_INDEX_LIMIT:0]       OP2,
  input  logic                            WB_REQ,
  input  logic [REG_ADDR_INDEX_LIMIT:0]   WB_ADDR,
  input  logic [DATA_INDEX_LIMIT:0]       WB_DATA,
  output logic                            WB_ACK,
  output logic                            RF_READ,
  output logic                            RF_WRITE,
  output logic [REG_ADDR_INDEX_LIMIT:0]   RF_ADDR_R1,
  output logic [REG_ADDR_INDEX_LIMIT:0]   RF_ADDR_R2,
  output logic [REG_ADDR_INDEX_LIMIT:0]   RF_ADDR_W,
  output logic [DATA_INDEX_LIMIT:0]       RF_DATA_W,
  input  logic [DATA_INDEX_LIMIT:0]       RF_DATA_R1,
  input  logic [DATA_INDEX_LIMIT:0]       RF_DATA_R2
);
  typedef enum logic [2:0] {IDLE, READ, RDONE, WRITE, WDONE} state_t;
  state_t state, state_nxt;
  logic wb_zero, r1_zero, r2_zero;
`ifdef RF_ZERO_GUARD_EN
  assign wb_zero = WB_ADDR == '0;
  assign r1_zero = RF_ADDR_R1 == '0;
  assign r2_zero = RF_ADDR_R2 == '0;
`else
  assign wb_zero = 1'b0;
  assign r1_zero = 1'b0;
  assign r2_zero = 1'b0;
`endif
  // next state: write-back wins in IDLE because it belongs to the older instruction
  always_comb begin
    state_nxt = (state == IDLE)  ? (WB_REQ ? WRITE : RD_REQ ? READ : IDLE) :
                (state == READ)  ? RDONE :
                (state == WRITE) ? WDONE : IDLE;
  end
  // state plus registered RF strobes/acks; addresses latch only on accept so later input changes are ignored
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      RF_READ    <= 1'b0;
      RF_WRITE   <= 1'b0;
      RD_ACK     <= 1'b0;
      WB_ACK     <= 1'b0;
      RF_ADDR_R1 <= '0;
      RF_ADDR_R2 <= '0;
      RF_ADDR_W  <= '0;
      RF_DATA_W  <= '0;
      OP1        <= '0;
      OP2        <= '0;
    end else begin
      state    <= state_nxt;
      RF_READ  <= state_nxt == READ;
      RF_WRITE <= state_nxt == WRITE && !wb_zero;
      RD_ACK   <= state_nxt == RDONE;
      WB_ACK   <= state_nxt == WDONE;
      if (state_nxt == WRITE) begin
        RF_ADDR_W <= WB_ADDR;
        RF_DATA_W <= WB_DATA;
      end
      if (state_nxt == READ) begin
        RF_ADDR_R1 <= RS_ADDR;
        RF_ADDR_R2 <= RT_ADDR;
      end
      if (state == READ) begin
        OP1 <= r1_zero ? '0 : RF_DATA_R1;
        OP2 <= r2_zero ? '0 : RF_DATA_R2;
      end
    end
  end
endmodule

// File: tb/tb_rf_access_ctrl.sv
// tb_rf_access_ctrl: directed self-checking bench for rf_access_ctrl with a behavioural 32x32 register file
module tb_rf_access_ctrl;
  logic        CLK, RST, RD_REQ, WB_REQ;
  logic [4:0]  RS_ADDR, RT_ADDR, WB_ADDR;
  logic [31:0] WB_DATA;
  logic        RD_ACK, WB_ACK, RF_READ, RF_WRITE;
  logic [31:0] OP1, OP2, RF_DATA_W, RF_DATA_R1, RF_DATA_R2;
  logic [4:0]  RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W;
  logic [31:0] mem [32];
  int pass_cnt, total_cnt, ovl_cnt, ack_cnt;
`ifdef RF_ZERO_GUARD_EN
  localparam logic [31:0] R0_INIT = 32'h0;
`else
  localparam logic [31:0] R0_INIT = 32'hA500_0000;
`endif

  rf_access_ctrl dut (
    .CLK(CLK), .RST(RST), .RD_REQ(RD_REQ), .RS_ADDR(RS_ADDR), .RT_ADDR(RT_ADDR),
    .RD_ACK(RD_ACK), .OP1(OP1), .OP2(OP2), .WB_REQ(WB_REQ), .WB_ADDR(WB_ADDR),
    .WB_DATA(WB_DATA), .WB_ACK(WB_ACK), .RF_READ(RF_READ), .RF_WRITE(RF_WRITE),
    .RF_ADDR_R1(RF_ADDR_R1), .RF_ADDR_R2(RF_ADDR_R2), .RF_ADDR_W(RF_ADDR_W),
    .RF_DATA_W(RF_DATA_W), .RF_DATA_R1(RF_DATA_R1), .RF_DATA_R2(RF_DATA_R2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hA500_0000 | i;
  end
  always @(posedge CLK) if (RF_WRITE) mem[RF_ADDR_W] = RF_DATA_W;
  assign RF_DATA_R1 = mem[RF_ADDR_R1];
  assign RF_DATA_R2 = mem[RF_ADDR_R2];

  always @(negedge CLK) begin
    if (RF_READ && RF_WRITE) ovl_cnt++;
    if (RD_ACK) ack_cnt++;
    if (WB_ACK) ack_cnt++;
  end

  task automatic do_read(input string tag, input logic [4:0] rs, input logic [4:0] rt, input logic [31:0] e1, input logic [31:0] e2);
    RS_ADDR = rs; RT_ADDR = rt; RD_REQ = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b1000) $display("FAIL %s_read_phase: got %b expected 1000", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    total_cnt++;
    if ({RF_ADDR_R1, RF_ADDR_R2} !== {rs, rt}) $display("FAIL %s_read_addr: got %0d/%0d expected %0d/%0d", tag, RF_ADDR_R1, RF_ADDR_R2, rs, rt); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0010) $display("FAIL %s_rdack_phase: got %b expected 0010", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    total_cnt++;
    if ({OP1, OP2} !== {e1, e2}) $display("FAIL %s_operands: got %h/%h expected %h/%h", tag, OP1, OP2, e1, e2); else pass_cnt++;
    RD_REQ = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0000) $display("FAIL %s_read_idle: got %b expected 0000", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
  endtask

  task automatic do_write(input string tag, input logic [4:0] wa, input logic [31:0] wd, input logic exp_wr);
    WB_ADDR = wa; WB_DATA = wd; WB_REQ = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== {1'b0, exp_wr, 2'b00}) $display("FAIL %s_write_phase: got %b expected 0%b00", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}, exp_wr); else pass_cnt++;
    total_cnt++;
    if ({RF_ADDR_W, RF_DATA_W} !== {wa, wd}) $display("FAIL %s_write_fields: got %0d/%h expected %0d/%h", tag, RF_ADDR_W, RF_DATA_W, wa, wd); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0001) $display("FAIL %s_wback_phase: got %b expected 0001", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    WB_REQ = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0000) $display("FAIL %s_write_idle: got %b expected 0000", tag, {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
  endtask

  task automatic test_reset;
    RST = 1'b1; RD_REQ = 1'b0; WB_REQ = 1'b0; RS_ADDR = '0; RT_ADDR = '0; WB_ADDR = '0; WB_DATA = '0;
    #2 RST = 1'b0;
    repeat (2) @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, OP1, OP2} !== '0) $display("FAIL reset_state: got nonzero outputs op1=%h rf_read=%b", OP1, RF_READ); else pass_cnt++;
    RST = 1'b1;
    do_read("pre_reset", 5'd1, 5'd2, 32'hA500_0001, 32'hA500_0002);
    RS_ADDR = 5'd3; RT_ADDR = 5'd4; RD_REQ = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if (RF_READ !== 1'b1) $display("FAIL reset_mid_read_active: got %b expected 1", RF_READ); else pass_cnt++;
    #2 RST = 1'b0;
    #1;
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W, OP1, OP2} !== '0) $display("FAIL reset_async_clear: got op1=%h op2=%h rf_read=%b addr_r1=%0d expected all 0", OP1, OP2, RF_READ, RF_ADDR_R1); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if (RD_ACK !== 1'b0) $display("FAIL reset_no_ack: got %b expected 0", RD_ACK); else pass_cnt++;
    RST = 1'b1;
    do_read("post_reset", 5'd3, 5'd4, 32'hA500_0003, 32'hA500_0004);
  endtask

  task automatic test_write_read;
    do_write("wr5", 5'd5, 32'hDEAD_BEEF, 1'b1);
    do_read("rd5", 5'd5, 5'd0, 32'hDEAD_BEEF, R0_INIT);
  endtask

  task automatic test_simultaneous;
    RS_ADDR = 5'd7; RT_ADDR = 5'd1; RD_REQ = 1'b1;
    WB_ADDR = 5'd7; WB_DATA = 32'h1234_5678; WB_REQ = 1'b1;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0100) $display("FAIL sim_write_first: got %b expected 0100", {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0001) $display("FAIL sim_wb_ack: got %b expected 0001", {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    WB_REQ = 1'b0;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK} !== 4'b0000) $display("FAIL sim_idle_gap: got %b expected 0000", {RF_READ, RF_WRITE, RD_ACK, WB_ACK}); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({RF_READ, RF_WRITE, RD_ACK, WB_ACK, RF_ADDR_R1} !== {4'b1000, 5'd7}) $display("FAIL sim_read_phase: got %b/%0d expected 1000/7", {RF_READ, RF_WRITE, RD_ACK, WB_ACK}, RF_ADDR_R1); else pass_cnt++;
    @(negedge CLK);
    total_cnt++;
    if ({RD_ACK, OP1, OP2} !== {1'b1, 32'h1234_5678, 32'hA500_0001}) $display("FAIL sim_rd_ack: got ack=%b op1=%h op2=%h expected 1/12345678/a5000001", RD_ACK, OP1, OP2); else pass_cnt++;
    RD_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_held_inputs;
    RS_ADDR = 5'd3; RT_ADDR = 5'd2; RD_REQ = 1'b1;
    @(negedge CLK);
    RS_ADDR = 5'd9; RT_ADDR = 5'd9;
    @(negedge CLK);
    total_cnt++;
    if ({RD_ACK, RF_ADDR_R1, RF_ADDR_R2} !== {1'b1, 5'd3, 5'd2}) $display("FAIL held_addr: got ack=%b r1=%0d r2=%0d expected 1/3/2", RD_ACK, RF_ADDR_R1, RF_ADDR_R2); else pass_cnt++;
    total_cnt++;
    if ({OP1, OP2} !== {32'hA500_0003, 32'hA500_0002}) $display("FAIL held_data: got %h/%h expected a5000003/a5000002", OP1, OP2); else pass_cnt++;
    RD_REQ = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    int a0, waited;
    logic got;
    logic [4:0] addr;
    logic [31:0] data;
    a0 = ack_cnt;
    for (int i = 0; i < 8; i++) begin
      addr = 5'(12 + i / 2);
      data = 32'hC0DE_0000 + 32'(i / 2);
      if (i % 2 == 0) begin
        RD_REQ = 1'b0; WB_ADDR = addr; WB_DATA = data; WB_REQ = 1'b1;
      end else begin
        WB_REQ = 1'b0; RS_ADDR = addr; RT_ADDR = addr; RD_REQ = 1'b1;
      end
      got = 1'b0;
      waited = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge CLK);
        waited++;
        if (RD_ACK || WB_ACK) begin
          got = 1'b1;
          break;
        end
      end
      total_cnt++;
      if (!got || {RD_ACK, WB_ACK} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) $display("FAIL b2b_ack_%0d: got rd_ack=%b wb_ack=%b found=%b", i, RD_ACK, WB_ACK, got); else pass_cnt++;
      total_cnt++;
      if (waited !== ((i == 0) ? 2 : 3)) $display("FAIL b2b_spacing_%0d: got %0d cycles expected %0d", i, waited, (i == 0) ? 2 : 3); else pass_cnt++;
      if (i % 2 == 1) begin
        total_cnt++;
        if ({OP1, OP2} !== {data, data}) $display("FAIL b2b_data_%0d: got %h/%h expected %h", i, OP1, OP2, data); else pass_cnt++;
      end
    end
    RD_REQ = 1'b0; WB_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    total_cnt++;
    if (ack_cnt - a0 !== 8) $display("FAIL b2b_ack_count: got %0d expected 8", ack_cnt - a0); else pass_cnt++;
  endtask

  task automatic test_zero_guard;
`ifdef RF_ZERO_GUARD_EN
    do_write("wr0", 5'd0, 32'hFFFF_FFFF, 1'b0);
    do_read("rd0", 5'd0, 5'd0, 32'h0, 32'h0);
`else
    do_write("wr0", 5'd0, 32'hFFFF_FFFF, 1'b1);
    do_read("rd0", 5'd0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`endif
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0; ovl_cnt = 0; ack_cnt = 0;
    test_reset;
    test_write_read;
    test_simultaneous;
    test_held_inputs;
    test_back_to_back;
    test_zero_guard;
    @(negedge CLK);
    total_cnt++;
    if (ovl_cnt !== 0) $display("FAIL read_write_overlap: got %0d overlapping cycles expected 0", ovl_cnt); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
